// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-requester arbiter for one shared synchronous block-RAM port.
//            Requester 0 is the CPU memory path and requester 1 is a
//            DMA/boot-loader master. The arbiter grants one access per cycle,
//            stalls the CPU when it loses, and follows the 1-cycle BRAM read
//            latency so that read data returns to the requester that issued
//            the read.
// Ports    : clk, rst (asynchronous, active-high)
//            cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_stall, cpu_rvalid, cpu_rdata
//            dma_req/dma_we/dma_addr/dma_wdata -> dma_gnt, dma_rvalid, dma_rdata
//            mem_en/mem_we/mem_addr/mem_wdata  -> BRAM port, mem_rdata <- BRAM
// Config   : MEM_ARB_RR_EN defined   -> contended cycles alternate CPU/DMA
//            MEM_ARB_RR_EN undefined -> CPU priority with a DMA starvation
//                                       counter bounded by STARVE_LIMIT
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW           = 12,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  // CPU requester
  input  logic          cpu_req,
  input  logic [3:0]    cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [31:0]   cpu_rdata,
  // DMA requester
  input  logic          dma_req,
  input  logic [3:0]    dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [31:0]   dma_rdata,
  // BRAM port
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  logic        dma_win;
  logic        cpu_win;
  logic        contend;

  logic        rd_pending_q, rd_pending_d;
  logic        rd_owner_q,   rd_owner_d;
  logic [31:0] cpu_rdata_q,  cpu_rdata_d;
  logic [31:0] dma_rdata_q,  dma_rdata_d;

`ifdef MEM_ARB_RR_EN
  // Set after a contended CPU win: the next contended cycle belongs to DMA.
  logic        rr_dma_q, rr_dma_d;
`else
  localparam logic [7:0] c_starve_limit = 8'(STARVE_LIMIT);
  logic [7:0]  starve_cnt_q, starve_cnt_d;
`endif

  // --------------------------------------------------------------------------
  // Grant decision and BRAM drive (combinational)
  // --------------------------------------------------------------------------
  always_comb begin
    contend = cpu_req & dma_req;
`ifdef MEM_ARB_RR_EN
    dma_win = dma_req & (~cpu_req | rr_dma_q);
`else
    dma_win = dma_req & (~cpu_req | (starve_cnt_q == c_starve_limit));
`endif
    // No access may reach the BRAM while reset is held.
    if (rst) begin
      dma_win = 1'b0;
    end
    cpu_win = cpu_req & ~dma_win & ~rst;

    mem_en    = cpu_win | dma_win;
    mem_addr  = dma_win ? dma_addr  : cpu_addr;
    mem_wdata = dma_win ? dma_wdata : cpu_wdata;
    mem_we    = 4'b0000;
    if (dma_win) begin
      mem_we = dma_we;
    end else if (cpu_win) begin
      mem_we = cpu_we;
    end

    dma_gnt   = dma_win;
    cpu_stall = cpu_req & dma_win;
  end

  // --------------------------------------------------------------------------
  // Arbitration state next-value
  // --------------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
  always_comb begin
    rr_dma_d = rr_dma_q;
    if (contend) begin
      rr_dma_d = cpu_win;
    end
  end
`else
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dma_req || dma_win) begin
      starve_cnt_d = 8'd0;
    end else if (contend && (starve_cnt_q < c_starve_limit)) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Read return path: the BRAM answers one cycle after the grant, so the
  // owner's rdata is taken straight from mem_rdata in that cycle and latched
  // so it holds while the other requester's reads come back.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_pending_d = mem_en & (mem_we == 4'b0000);
    rd_owner_d   = dma_win;

    cpu_rvalid   = rd_pending_q & ~rd_owner_q;
    dma_rvalid   = rd_pending_q &  rd_owner_q;

    cpu_rdata_d  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    dma_rdata_d  = dma_rvalid ? mem_rdata : dma_rdata_q;

    cpu_rdata    = cpu_rdata_d;
    dma_rdata    = dma_rdata_d;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      dma_rdata_q  <= 32'd0;
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_dma_q <= 1'b0;
    end else begin
      rr_dma_q <= rr_dma_d;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= 8'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

endmodule
`default_nettype wire
